// File: rtl/mriscv_pkg.sv
// Shared encodings for the memory-access stage: func3 sizes, fault causes and FSM states.
package mriscv_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  function automatic logic f3_illegal(input logic ld, input logic st, input logic [2:0] f3);
    if (ld && st) return 1'b1;
    if (ld)       return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if (st)       return (f3 >= 3'b011);
    return 1'b0;
  endfunction

  // func3[1:0] carries the access size for both signed and unsigned loads
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replicated write data and load lane extraction/extension.
module lsu_align
  import mriscv_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_store_data;
    case (i_func3[1:0])
      2'b00: begin
        o_wstrb = 4'b0001 << i_off;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_wstrb = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_shift     = i_rdata >> {i_off, 3'b000};
    w_byte      = w_shift[7:0];
    w_half      = w_shift[15:0];
    o_load_data = i_rdata;
    case (i_func3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues one aligned bus transaction per load/store, with fault and timeout pulses.
module mem_access
  import mriscv_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause
);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [2:0]  r_func3;
  logic [1:0]  r_off;
  logic [4:0]  r_dest;
  logic        r_wb_valid;
  logic [4:0]  r_wb_dest;
  logic [31:0] r_wb_data;
  logic        r_exc_valid;
  logic [1:0]  r_exc_cause;

  logic        w_accept, w_memop, w_illegal, w_misalign, w_timeout, w_start;
  logic [2:0]  w_al_func3;
  logic [1:0]  w_al_off;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_load_data;

  // One aligner serves both directions: accept-time inputs in IDLE, latched access in BUS
  assign w_al_func3 = (r_state == ST_BUS) ? r_func3 : func3;
  assign w_al_off   = (r_state == ST_BUS) ? r_off   : result[1:0];

  lsu_align u_align (
    .i_func3      (w_al_func3),
    .i_off        (w_al_off),
    .i_store_data (store_data),
    .i_rdata      (mem_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  always_comb begin
    w_accept   = in_valid && (r_state == ST_IDLE);
    w_memop    = is_load || is_store;
    w_illegal  = f3_illegal(is_load, is_store, func3);
    w_misalign = misaligned(func3, result[1:0]);
    w_start    = w_accept && w_memop && !w_illegal && !w_misalign;
    w_timeout  = (TIMEOUT_CYCLES != 8'd0) && (r_cnt == TIMEOUT_CYCLES - 8'd1);
    w_next     = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_BUS;
      ST_BUS:  if (mem_ack || w_timeout) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wstrb     <= '0;
      r_wdata     <= '0;
      r_func3     <= '0;
      r_off       <= '0;
      r_dest      <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_dest   <= '0;
      r_wb_data   <= '0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= EXC_NONE;
    end else begin
      r_wb_valid  <= 1'b0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= EXC_NONE;
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          if (!w_memop) begin
            r_wb_valid <= (dest_i != 5'd0);
            r_wb_data  <= result;
            r_wb_dest  <= dest_i;
          end else if (w_illegal) begin
            r_exc_valid <= 1'b1;
            r_exc_cause <= EXC_ILLEGAL;
          end else if (w_misalign) begin
            r_exc_valid <= 1'b1;
            r_exc_cause <= EXC_MISALIGN;
          end else begin
            r_addr  <= {result[31:2], 2'b00};
            r_we    <= is_store;
            r_wstrb <= is_store ? w_wstrb : 4'b0000;
            r_wdata <= is_store ? w_wdata : '0;
            r_func3 <= func3;
            r_off   <= result[1:0];
            r_dest  <= dest_i;
            r_cnt   <= '0;
          end
        end
      end else begin
        if (mem_ack) begin
          if (!r_we) begin
            r_wb_valid <= (r_dest != 5'd0);
            r_wb_data  <= w_load_data;
            r_wb_dest  <= r_dest;
          end
        end else if (w_timeout) begin
          r_exc_valid <= 1'b1;
          r_exc_cause <= EXC_TIMEOUT;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign mem_req   = (r_state == ST_BUS);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wstrb = r_wstrb;
  assign mem_wdata = r_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_dest   = r_wb_dest;
  assign wb_data   = r_wb_data;
  assign exc_valid = r_exc_valid;
  assign exc_cause = r_exc_cause;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, 8-bit range 0..255: ack-less bus cycles before abort; 0 disables the timeout.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream (execute stage) presents an operation.
REQ-005 in_ready  output  1  block can accept; equals (state==IDLE).
REQ-006 is_load, is_store  input  1 each  operation class; neither set = pass-through.
REQ-007 func3  input  3  access size/signedness.
REQ-008 result  input  32  effective address (load/store) or pass-through data.
REQ-009 store_data  input  32  rs2 value for stores.
REQ-010 dest_i  input  5  destination register.
REQ-011 mem_req, mem_we  output  1 each  bus request, write enable.
REQ-012 mem_addr  output  32  word-aligned address (bits [1:0]=0).
REQ-013 mem_wstrb  output  4  byte strobes; mem_wdata  output  32  write data.
REQ-014 mem_rdata  input  32; mem_ack  input  1  bus completion, single cycle.
REQ-015 wb_valid  output  1; wb_dest  output  5; wb_data  output  32  writeback pulse.
REQ-016 exc_valid  output  1; exc_cause  output  2  fault pulse: 01 misaligned, 10 bus timeout, 11 illegal.

Function
REQ-017 FSM states IDLE, BUS; accept on rising edge when in_valid && in_ready.
REQ-018 Pass-through: accepted cycle N -> wb_valid=1, wb_data=result, wb_dest=dest_i in cycle N+1; state stays IDLE.
REQ-019 Load/store checks at accept: is_load&&is_store, load func3 in {011,110,111} or store func3 >= 011 -> exc_valid/exc_cause=11 in N+1, no bus access.
REQ-020 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> exc_cause=01 in N+1, no bus access.
REQ-021 Valid access: state BUS from N+1; mem_req=1 with mem_addr, mem_we, mem_wstrb, mem_wdata stable until the edge sampling mem_ack=1.
REQ-022 Store lanes: sb strobe 1<<addr[1:0], wdata byte replicated x4; sh strobe 0011/1100 per addr[1], wdata half replicated x2; sw strobe 1111.
REQ-023 Loads: mem_wstrb=0000; lane selected by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw unmodified.
REQ-024 On ack edge: state -> IDLE, mem_req=0 next cycle; load -> wb_valid pulse next cycle with extended data; store -> no wb_valid.
REQ-025 wb_valid suppressed whenever wb_dest would be 0 (x0), for loads and pass-through.
REQ-026 Timeout counter clears on entering BUS, increments each BUS cycle without ack; at TIMEOUT_CYCLES -> IDLE, mem_req drops, exc_cause=10 pulse next cycle.
REQ-027 mem_ack on the same cycle the counter expires: ack wins, no exception.
REQ-028 mem_ack while IDLE ignored; exc_valid and wb_valid never both high; each pulse exactly one cycle.

Reset
REQ-029 reset forces IDLE, counter 0, and all outputs 0 (in_ready=1) on the next edge, including mid-BUS; pending load discarded, no wb/exc pulse.
REQ-030 An ack arriving in the reset cycle is ignored.

Structure
REQ-031 Shared package mriscv_pkg holds func3 load/store encodings, exc_cause codes, FSM state encoding.
REQ-032 One combinational sub-module lsu_align: store lane/strobe generation and load extraction/extension.

Verification
REQ-033 Pass-through result=0x12345678, dest_i=5 -> next cycle wb_valid=1, wb_data=0x12345678, wb_dest=5.
REQ-034 lb addr=0x00001003, rdata=0x80000000, ack after 3 cycles -> mem_addr=0x00001000, wb_data=0xFFFFFF80; lbu same -> 0x00000080.
REQ-035 sh addr=0x00002002, store_data=0x0000BEEF -> mem_addr=0x00002000, wstrb=1100, wdata=0xBEEFBEEF, mem_we=1, no wb_valid.
REQ-036 lw addr=0x00001001 -> exc_cause=01 next cycle, mem_req never asserted, in_ready stays 1.
REQ-037 lw with no ack, TIMEOUT_CYCLES=16 -> mem_req high 16 cycles, then exc_cause=10; repeat with ack on 16th cycle -> wb_valid, no exc.
REQ-038 reset asserted on 2nd BUS cycle of a load -> mem_req=0 next cycle, no wb_valid, in_ready=1.
